// File: rtl/beat_sequencer_pkg.sv
// Shared types and defaults for the beat-slot record/playback controller.
// Record and playback FSM state encodings live here.
package beat_sequencer_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int NOTE_W_DEF  = 7;
  localparam int NOTE_SILENT = 0;

  typedef enum logic {
    R_IDLE,
    R_REC
  } rec_st_t;

  typedef enum logic {
    P_IDLE,
    P_PLAY
  } play_st_t;

endpackage

// File: rtl/beat_sequencer_slot_player.sv
// Per-slot playback: read pointer, 2-cycle RAM latency tracking, note out.
// BEAT_LOOP_EN: wrap to the slot start instead of stopping at the end.
module beat_sequencer_slot_player
  import beat_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   len,
  input  logic [NOTE_W-1:0] ram_q,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [NOTE_W-1:0] note,
  output logic              playing
);

  play_st_t          st, st_n;
  logic [ADDR_W:0]   rd_ptr, rd_ptr_n;
  logic [1:0]        vld, vld_n;
  logic [NOTE_W-1:0] note_n;
  logic              at_end;

  assign at_end  = (rd_ptr == len);
  assign playing = (st == P_PLAY);

  always_comb begin
    st_n     = st;
    rd_ptr_n = rd_ptr;
    vld_n    = {vld[0], 1'b0};
    note_n   = vld[1] ? ram_q : note;
    rd_en    = 1'b0;
    rd_addr  = rd_ptr[ADDR_W-1:0];
    unique case (st)
      P_IDLE: begin
        if (start) begin
          st_n     = P_PLAY;
          rd_ptr_n = '0;
        end
      end
      P_PLAY: begin
        if (stop) begin
          st_n   = P_IDLE;
          vld_n  = '0;
          note_n = NOTE_W'(NOTE_SILENT);
        end else if (tick) begin
          if (at_end) begin
`ifdef BEAT_LOOP_EN
            rd_en    = 1'b1;
            rd_addr  = '0;
            vld_n[0] = 1'b1;
            rd_ptr_n = (ADDR_W+1)'(1);
`else
            st_n   = P_IDLE;
            vld_n  = '0;
            note_n = NOTE_W'(NOTE_SILENT);
`endif
          end else begin
            rd_en    = 1'b1;
            vld_n[0] = 1'b1;
            rd_ptr_n = rd_ptr + (ADDR_W+1)'(1);
          end
        end
      end
      default: st_n = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= P_IDLE;
      rd_ptr <= '0;
      vld    <= '0;
      note   <= '0;
    end else begin
      st     <= st_n;
      rd_ptr <= rd_ptr_n;
      vld    <= vld_n;
      note   <= note_n;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Beat-slot record/playback controller owning the A/B RAM ports.
// BEAT_LOOP_EN: slots loop on playback until stopped.
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NOTE_W   = NOTE_W_DEF,
  parameter int TICK_DIV = 2_500_000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [NOTE_W-1:0] key_note,
  input  logic              rec_req,
  input  logic              rec_slot,
  input  logic [1:0]        play_req,
  input  logic              stop_req,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic              ram_wren_a,
  output logic [NOTE_W-1:0] ram_data_a,
  input  logic [NOTE_W-1:0] ram_q_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_wren_b,
  output logic [NOTE_W-1:0] ram_data_b,
  input  logic [NOTE_W-1:0] ram_q_b,
  output logic [NOTE_W-1:0] note_a,
  output logic [NOTE_W-1:0] note_b,
  output logic              recording,
  output logic [1:0]        playing,
  output logic [1:0]        saved
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else         cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

  rec_st_t                st, st_n;
  logic                   rs, rs_n;
  logic [ADDR_W-1:0]      wr_ptr, wr_ptr_n;
  logic [1:0][ADDR_W:0]   len, len_n;
  logic [1:0]             saved_n;
  logic                   wr, rec_start;
  logic [ADDR_W:0]        n_wr;

  // n_wr counts the tick write that may coincide with the stop
  assign n_wr = {1'b0, wr_ptr} + (ADDR_W+1)'(tick);

  always_comb begin
    st_n      = st;
    rs_n      = rs;
    wr_ptr_n  = wr_ptr;
    len_n     = len;
    saved_n   = saved;
    wr        = 1'b0;
    rec_start = 1'b0;
    unique case (st)
      R_IDLE: begin
        if (rec_req && !stop_req) begin
          rec_start = 1'b1;
          rs_n      = rec_slot;
          wr_ptr_n  = '0;
          st_n      = R_REC;
        end
      end
      R_REC: begin
        wr = tick;
        if (tick) wr_ptr_n = wr_ptr + ADDR_W'(1);
        if ((tick && &wr_ptr) || rec_req || stop_req) begin
          st_n        = R_IDLE;
          len_n[rs]   = n_wr;
          saved_n[rs] = |n_wr;
        end
      end
      default: st_n = R_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      st     <= R_IDLE;
      rs     <= 1'b0;
      wr_ptr <= '0;
      len    <= '0;
      saved  <= '0;
    end else begin
      st     <= st_n;
      rs     <= rs_n;
      wr_ptr <= wr_ptr_n;
      len    <= len_n;
      saved  <= saved_n;
    end
  end

  assign recording = (st == R_REC);

  logic [1:0]                busy, rec_hit, p_start, p_stop, rd_en;
  logic [1:0][ADDR_W-1:0]    rd_addr;
  logic [1:0][NOTE_W-1:0]    q, note;

  assign q[0] = ram_q_a;
  assign q[1] = ram_q_b;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    assign busy[i]    = recording && (rs == 1'(i));
    assign rec_hit[i] = rec_start && (rec_slot == 1'(i));
    assign p_start[i] = play_req[i] && saved[i] && !busy[i] && !rec_hit[i];
    assign p_stop[i]  = stop_req || play_req[i] || rec_hit[i];

    beat_sequencer_slot_player #(
      .ADDR_W (ADDR_W),
      .NOTE_W (NOTE_W)
    ) u_player (
      .clk     (CLOCK_50),
      .rst_n   (resetn),
      .tick    (tick),
      .start   (p_start[i]),
      .stop    (p_stop[i]),
      .len     (len[i]),
      .ram_q   (q[i]),
      .rd_en   (rd_en[i]),
      .rd_addr (rd_addr[i]),
      .note    (note[i]),
      .playing (playing[i])
    );
  end

  logic [1:0][ADDR_W-1:0] addr_r;
  logic [1:0]             wren_r;
  logic [1:0][NOTE_W-1:0] data_r;

  // recording owns the port of its slot; otherwise the player's address
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      addr_r <= '0;
      wren_r <= '0;
      data_r <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wren_r[i] <= wr && (rs == 1'(i));
        if (busy[i])       addr_r[i] <= wr_ptr;
        else if (rd_en[i]) addr_r[i] <= rd_addr[i];
        if (wr && (rs == 1'(i))) data_r[i] <= key_note;
      end
    end
  end

  assign ram_addr_a = addr_r[0];
  assign ram_wren_a = wren_r[0];
  assign ram_data_a = data_r[0];
  assign ram_addr_b = addr_r[1];
  assign ram_wren_b = wren_r[1];
  assign ram_data_b = data_r[1];
  assign note_a     = note[0];
  assign note_b     = note[1];

endmodule
